crc_parallel_param: RTL and testbench



---
 rtl/crc_parallel_param.sv | 158 +++++++++++++++
 tb/tb_crc_parallel_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_parallel_param.sv
// Parametrised parallel CRC engine: absorbs DATA_W bits per accepted beat, framed by start/finish.
// Optional CRC_CHECK_EN adds an expected_crc input and a registered crc_match result flag.
module crc_parallel_param #(
    parameter int unsigned      CRC_W       = 16,
    parameter int unsigned      DATA_W      = 8,
    parameter logic [CRC_W-1:0] POLY        = CRC_W'(16'h1021),
    parameter logic [CRC_W-1:0] INIT        = CRC_W'(16'hFFFF),
    parameter logic [CRC_W-1:0] XOR_OUT     = CRC_W'(16'h0000),
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_ready,
    input  logic              finish,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    output logic              busy,
`ifdef CRC_CHECK_EN
    input  logic [CRC_W-1:0]  expected_crc,
    output logic              crc_match,
`endif
    output logic [15:0]       beat_count
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   crc_out_q;
    logic               crc_valid_q;
    logic               busy_q;
    logic               data_ready_q;
    logic [CNT_W-1:0]   beat_count_q;
`ifdef CRC_CHECK_EN
    logic               crc_match_q;
`endif

    logic               accept_c;
    logic [CRC_W-1:0]   crc_d;
    logic [CRC_W-1:0]   result_d;

    // Unrolled LFSR: every data bit of the beat is folded in within one cycle.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                  input logic [DATA_W-1:0] din);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = 0; i < int'(DATA_W); i++) begin
            fb = c[CRC_W-1] ^ (REFLECT_IN ? din[i] : din[int'(DATA_W) - 1 - i]);
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CRC_W); i++) begin
            r[i] = v[int'(CRC_W) - 1 - i];
        end
        return r;
    endfunction

    // data_ready_q is high exactly while the state register holds RUN.
    always_comb begin
        accept_c = data_valid & data_ready_q;
        crc_d    = accept_c ? crc_step(crc_q, data_in) : crc_q;
        result_d = (REFLECT_OUT ? bitrev(crc_d) : crc_d) ^ XOR_OUT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            crc_q        <= INIT;
            crc_out_q    <= '0;
            crc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
            beat_count_q <= '0;
`ifdef CRC_CHECK_EN
            crc_match_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        crc_q        <= INIT;
                        beat_count_q <= '0;
                        busy_q       <= 1'b1;
                        data_ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        // Restart drops any beat presented in the same cycle.
                        crc_q        <= INIT;
                        beat_count_q <= '0;
                    end else begin
                        crc_q <= crc_d;
                        if (accept_c && (beat_count_q != CNT_MAX)) begin
                            beat_count_q <= beat_count_q + CNT_W'(1);
                        end
                        if (finish) begin
                            state_q      <= S_DONE;
                            crc_out_q    <= result_d;
                            crc_valid_q  <= 1'b1;
                            busy_q       <= 1'b0;
                            data_ready_q <= 1'b0;
`ifdef CRC_CHECK_EN
                            crc_match_q  <= (result_d == expected_crc);
`endif
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        crc_q        <= INIT;
                        beat_count_q <= '0;
                        crc_valid_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        data_ready_q <= 1'b1;
`ifdef CRC_CHECK_EN
                        crc_match_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    data_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign crc_out    = crc_out_q;
    assign crc_valid  = crc_valid_q;
    assign busy       = busy_q;
    assign data_ready = data_ready_q;
    assign beat_count = beat_count_q;
`ifdef CRC_CHECK_EN
    assign crc_match  = crc_match_q;
`endif

endmodule

// File: tb/tb_crc_parallel_param.sv
// Bench for crc_parallel_param: a CRC-16/CCITT-FALSE instance and a CRC-16/ARC instance share stimulus
// and are checked against byte-wise reference CRC functions. Define CRC_CHECK_EN to cover crc_match.
module tb_crc_parallel_param;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic        start;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        finish;

    logic        d0_ready, d0_valid, d0_busy;
    logic [15:0] d0_crc, d0_cnt;
    logic        d1_ready, d1_valid, d1_busy;
    logic [15:0] d1_crc, d1_cnt;
`ifdef CRC_CHECK_EN
    logic [15:0] exp0, exp1;
    logic        m0, m1;
`endif

    int vectors;
    int miscompares;

    crc_parallel_param u_ccitt (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (d0_ready),
        .finish     (finish),
        .crc_out    (d0_crc),
        .crc_valid  (d0_valid),
        .busy       (d0_busy),
`ifdef CRC_CHECK_EN
        .expected_crc (exp0),
        .crc_match    (m0),
`endif
        .beat_count (d0_cnt)
    );

    crc_parallel_param #(
        .CRC_W(16), .DATA_W(8), .POLY(16'h8005), .INIT(16'h0000), .XOR_OUT(16'h0000),
        .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
    ) u_arc (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (d1_ready),
        .finish     (finish),
        .crc_out    (d1_crc),
        .crc_valid  (d1_valid),
        .busy       (d1_busy),
`ifdef CRC_CHECK_EN
        .expected_crc (exp1),
        .crc_match    (m1),
`endif
        .beat_count (d1_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Byte-at-a-time CRC-16/CCITT-FALSE.
    function automatic logic [15:0] ref_ccitt(input bq_t m);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (m[k]) begin
            c = c ^ {m[k], 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Right-shifting reflected CRC-16/ARC with reversed polynomial 0xA001.
    function automatic logic [15:0] ref_arc(input bq_t m);
        logic [15:0] c;
        c = 16'h0000;
        foreach (m[k]) begin
            c = c ^ {8'h00, m[k]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit with_beat);
        start      = 1'b1;
        data_valid = with_beat;
        data_in    = 8'hA5;
        step();
        start      = 1'b0;
        data_valid = 1'b0;
    endtask

    // Streams msg, optionally with random idle gaps, optionally merging finish into the last beat.
    task automatic send(input bq_t msg, input bit gaps, input bit fin_with_last);
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    data_valid = 1'b0;
                    data_in    = 8'($urandom);
                    step();
                end
            end
            data_valid = 1'b1;
            data_in    = msg[i];
            finish     = fin_with_last && (i == msg.size() - 1);
            step();
        end
        data_valid = 1'b0;
        if (!(fin_with_last && msg.size() > 0)) begin
            finish = 1'b1;
            step();
        end
        finish = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_valid = 1'b1; finish = 1'b1; data_in = 8'h31;
        step();
        step();
        vectors++; if ({d0_crc, d0_valid, d0_busy, d0_ready, d0_cnt} !== 35'h0) begin miscompares++; $display("FAIL reset_d0 got crc=%h v=%b b=%b r=%b cnt=%0d want all zero", d0_crc, d0_valid, d0_busy, d0_ready, d0_cnt); end
        vectors++; if ({d1_crc, d1_valid, d1_busy, d1_ready, d1_cnt} !== 35'h0) begin miscompares++; $display("FAIL reset_d1 got crc=%h v=%b b=%b r=%b cnt=%0d want all zero", d1_crc, d1_valid, d1_busy, d1_ready, d1_cnt); end
        rst = 1'b0; start = 1'b0; data_valid = 1'b0; finish = 1'b0;
        step();
    endtask

    task automatic test_known();
        bq_t msg;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        do_start(1'b0);
        foreach (msg[i]) begin
            data_valid = 1'b1; data_in = msg[i];
            step();
        end
        data_valid = 1'b0;
        vectors++; if ({d0_valid, d0_busy, d0_ready} !== 3'b011 || d0_cnt !== 16'd9) begin miscompares++; $display("FAIL known_pre_finish got v=%b b=%b r=%b cnt=%0d want v=0 b=1 r=1 cnt=9", d0_valid, d0_busy, d0_ready, d0_cnt); end
        finish = 1'b1;
        step();
        finish = 1'b0;
        vectors++; if (d0_crc !== 16'h29B1 || d0_valid !== 1'b1) begin miscompares++; $display("FAIL known_ccitt got %h v=%b want 29b1 v=1", d0_crc, d0_valid); end
        vectors++; if (d0_cnt !== 16'd9 || d0_busy !== 1'b0 || d0_ready !== 1'b0) begin miscompares++; $display("FAIL known_ccitt_done got cnt=%0d b=%b r=%b want cnt=9 b=0 r=0", d0_cnt, d0_busy, d0_ready); end
        vectors++; if (d1_crc !== 16'hBB3D || d1_valid !== 1'b1) begin miscompares++; $display("FAIL known_arc got %h v=%b want bb3d v=1", d1_crc, d1_valid); end
        vectors++; if (ref_ccitt(msg) !== d0_crc || ref_arc(msg) !== d1_crc) begin miscompares++; $display("FAIL known_model got %h/%h want %h/%h", d0_crc, d1_crc, ref_ccitt(msg), ref_arc(msg)); end
    endtask

    task automatic test_empty();
        bq_t none;
        none = {};
        do_start(1'b0);
        send(none, 1'b0, 1'b0);
        vectors++; if (d0_crc !== 16'hFFFF || d0_cnt !== 16'd0 || d0_valid !== 1'b1) begin miscompares++; $display("FAIL empty_ccitt got %h cnt=%0d v=%b want ffff cnt=0 v=1", d0_crc, d0_cnt, d0_valid); end
        vectors++; if (d1_crc !== ref_arc(none)) begin miscompares++; $display("FAIL empty_arc got %h want %h", d1_crc, ref_arc(none)); end
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1; data_in = 8'($urandom); finish = (i == 1);
            step();
            vectors++; if (d0_crc !== 16'hFFFF || d0_cnt !== 16'd0 || d0_valid !== 1'b1 || d0_ready !== 1'b0) begin miscompares++; $display("FAIL done_ignore got %h cnt=%0d v=%b r=%b want ffff cnt=0 v=1 r=0", d0_crc, d0_cnt, d0_valid, d0_ready); end
        end
        data_valid = 1'b0; finish = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1; data_in = 8'($urandom); finish = (i == 2);
            step();
            vectors++; if ({d0_crc, d0_valid, d0_busy, d0_ready, d0_cnt} !== 35'h0) begin miscompares++; $display("FAIL idle_ignore got crc=%h v=%b b=%b r=%b cnt=%0d want all zero", d0_crc, d0_valid, d0_busy, d0_ready, d0_cnt); end
        end
        data_valid = 1'b0; finish = 1'b0;
    endtask

    task automatic test_gapped_restart();
        bq_t msg;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        do_start(1'b0);
        send(msg, 1'b1, 1'b1);
        vectors++; if (d0_crc !== 16'h29B1 || d1_crc !== 16'hBB3D || d0_cnt !== 16'd9) begin miscompares++; $display("FAIL gapped got %h/%h cnt=%0d want 29b1/bb3d cnt=9", d0_crc, d1_crc, d0_cnt); end
        do_start(1'b0);
        vectors++; if (d0_valid !== 1'b0 || d0_busy !== 1'b1 || d0_cnt !== 16'd0) begin miscompares++; $display("FAIL done_start got v=%b b=%b cnt=%0d want v=0 b=1 cnt=0", d0_valid, d0_busy, d0_cnt); end
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1; data_in = msg[i];
            step();
        end
        data_valid = 1'b0;
        vectors++; if (d0_cnt !== 16'd4) begin miscompares++; $display("FAIL partial_cnt got %0d want 4", d0_cnt); end
        finish = 1'b1;
        do_start(1'b1);
        finish = 1'b0;
        vectors++; if (d0_cnt !== 16'd0 || d0_busy !== 1'b1 || d0_valid !== 1'b0) begin miscompares++; $display("FAIL restart got cnt=%0d b=%b v=%b want cnt=0 b=1 v=0", d0_cnt, d0_busy, d0_valid); end
        send(msg, 1'b0, 1'b0);
        vectors++; if (d0_crc !== 16'h29B1 || d1_crc !== 16'hBB3D || d0_cnt !== 16'd9) begin miscompares++; $display("FAIL restart_result got %h/%h cnt=%0d want 29b1/bb3d cnt=9", d0_crc, d1_crc, d0_cnt); end
    endtask

    task automatic test_reset_mid();
        bq_t msg;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        do_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            data_valid = 1'b1; data_in = msg[i];
            step();
        end
        rst = 1'b1; finish = 1'b1;
        step();
        rst = 1'b0; finish = 1'b0; data_valid = 1'b0;
        vectors++; if ({d0_crc, d0_valid, d0_busy, d0_ready, d0_cnt} !== 35'h0) begin miscompares++; $display("FAIL reset_mid got crc=%h v=%b b=%b r=%b cnt=%0d want all zero", d0_crc, d0_valid, d0_busy, d0_ready, d0_cnt); end
        do_start(1'b0);
        send(msg, 1'b0, 1'b0);
        vectors++; if (d0_crc !== 16'h29B1 || d1_crc !== 16'hBB3D || d0_cnt !== 16'd9) begin miscompares++; $display("FAIL after_reset got %h/%h cnt=%0d want 29b1/bb3d cnt=9", d0_crc, d1_crc, d0_cnt); end
    endtask

    task automatic test_random();
        bq_t msg;
        int  len;
        for (int n = 0; n < 25; n++) begin
            len = int'($urandom_range(0, 24));
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            do_start(1'($urandom));
            send(msg, 1'($urandom), 1'($urandom));
            vectors++; if (d0_crc !== ref_ccitt(msg) || d0_cnt !== 16'(len) || d0_valid !== 1'b1) begin miscompares++; $display("FAIL random_ccitt msg%0d got %h cnt=%0d v=%b want %h cnt=%0d v=1", n, d0_crc, d0_cnt, d0_valid, ref_ccitt(msg), len); end
            vectors++; if (d1_crc !== ref_arc(msg) || d1_cnt !== 16'(len)) begin miscompares++; $display("FAIL random_arc msg%0d got %h cnt=%0d want %h cnt=%0d", n, d1_crc, d1_cnt, ref_arc(msg), len); end
        end
    endtask

`ifdef CRC_CHECK_EN
    task automatic test_check();
        bq_t msg;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp0 = 16'h29B1; exp1 = 16'hBB3D;
        do_start(1'b0);
        send(msg, 1'b0, 1'b0);
        vectors++; if (m0 !== 1'b1 || m1 !== 1'b1) begin miscompares++; $display("FAIL match_hit got %b/%b want 1/1", m0, m1); end
        exp0 = 16'h29B0; exp1 = 16'hBB3C;
        do_start(1'b0);
        send(msg, 1'b1, 1'b1);
        vectors++; if (m0 !== 1'b0 || m1 !== 1'b0) begin miscompares++; $display("FAIL match_miss got %b/%b want 0/0", m0, m1); end
        exp0 = 16'h29B1;
        do_start(1'b0);
        send(msg, 1'b0, 1'b0);
        do_start(1'b0);
        vectors++; if (m0 !== 1'b0) begin miscompares++; $display("FAIL match_clear got %b want 0", m0); end
        finish = 1'b1;
        step();
        finish = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = 8'h00; finish = 1'b0;
`ifdef CRC_CHECK_EN
        exp0 = 16'h0000; exp1 = 16'h0000;
`endif
        test_reset();
        test_known();
        test_empty();
        test_gapped_restart();
        test_reset_mid();
        test_random();
`ifdef CRC_CHECK_EN
        test_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
